decoder_layer_sequencer: RTL and testbench
==========================================

# decoder_layer_sequencer

Sequences the contextual decoder's eight convolution layers onto one shared, time-multiplexed conv engine. For each layer it drives a start/done handshake and presents a stable per-layer configuration: shapes, weight/bias base addresses, pixel-shuffle, ReLU, residual and context-concat selects. It sits between the decoder top-level control (start/done) and the conv engine plus its feature/weight buffers.

## Interface
- DATA_WIDTH, 32, element width; used only for address scaling docs, addresses are in elements
- CHANNEL_N, 64, decoder N channels
- CHANNEL_M, 96, decoder M (latent) channels
- HEIGHT, 4, input latent height
- WIDTH, 4, input latent width
- ADDR_W, 24, weight/bias address width (elements)
- TIMEOUT_CYCLES, 1048576, engine watchdog limit (only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a full decode pass; sampled in IDLE only
- abort  in  1  synchronous abort; returns to IDLE next cycle, no done pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky timeout flag, cleared on accepted start
- eng_start  out  1  one-cycle pulse launching current layer
- eng_done  in  1  engine completion pulse
- layer_idx  out  3  current layer 0..7
- cfg_in_ch, cfg_out_ch  out  8 each  layer channel counts
- cfg_h, cfg_w  out  8 each  layer input spatial size
- cfg_wbase, cfg_bbase  out  ADDR_W each  weight/bias base
- cfg_ps_en  out  1  pixel shuffle (r=2) on output
- cfg_relu_in  out  1  ReLU on input
- cfg_res_add  out  1  add residual buffer after conv, then ReLU
- cfg_ctx_sel  out  2  input concat: 0 none, 1 context3, 2 context2
- cycle_cnt  out  32  cycles of last/current pass, saturating at 0xFFFFFFFF

## Operation
Layer table, in:out channels, size, flags:
- 0 up1: M:4N, H×W, ps
- 1 up2: N:4N, 2H×2W, ps
- 2 res1a: 2N:N, 4H×4W, relu_in, ctx=1
- 3 res1b: N:2N, 4H×4W, relu_in, res_add
- 4 up3: 2N:4N, 4H×4W, ps
- 5 res2a: 2N:N, 8H×8W, relu_in, ctx=2
- 6 res2b: N:2N, 8H×8W, relu_in, res_add
- 7 up4: 2N:128, 8H×8W, ps

Addresses:
- cfg_wbase(k) = Σ_{j<k} out_j·in_j·9
- cfg_bbase(k) = Σ_{j<k} out_j
- Both computed at elaboration.

FSM (IDLE, ISSUE, WAIT, NEXT, FIN, plus ERR with macro):
- IDLE: start → ISSUE with layer_idx=0, cycle_cnt=0, err=0.
- ISSUE: eng_start=1 for exactly one cycle → WAIT.
- WAIT: eng_done → NEXT; other inputs ignored.
- NEXT: layer_idx==7 → FIN; otherwise layer_idx+1 → ISSUE.
- FIN: done=1 → IDLE.
- abort in any non-IDLE state → IDLE, eng_start suppressed. abort has priority over eng_done in the same cycle.
- start while busy is ignored.
- eng_done outside WAIT is ignored.

Outputs and counters:
- All cfg_* outputs are a registered decode of layer_idx. They are stable from ISSUE through NEXT.
- cycle_cnt increments every busy cycle and holds its value in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, layer_idx 0.
- start at cycle t → eng_start at t+1.
- eng_done at cycle d → next eng_start at d+2; the final done pulse is at d+2 after layer 7.
- Fixed overhead per pass: 1 + 8·2 cycles plus engine time.
- Engine latency of 1 (eng_done the cycle after eng_start) is legal.

## Configuration
SEQ_TIMEOUT_EN:
- Defined: a WAIT counter clears on entry to WAIT. Reaching TIMEOUT_CYCLES → ERR: err=1 sticky, done pulses once, then IDLE.
- Undefined: WAIT is unbounded, err is tied 0, no counter is synthesized.

## Structure
- Package decoder_seq_pkg holds:
  - state enum
  - layer count constant (8)
  - layer-config struct
  - elaboration function building the config ROM from N/M/H/W
- Sub-module decoder_layer_rom: combinational layer_idx → config; the sequencer registers its output.

## Test plan
- Defaults, engine done 5 cycles after each start → 8 eng_start pulses; done at cycle 1+8·(5+2)=57 after start; cycle_cnt=56.
- Check ROM at defaults:
  - Layer 1: wbase=221184, bbase=256.
  - Layer 2: in=128, out=64, h=w=16, ctx=1.
  - Layer 7: out=128, h=w=32, ps=1.
- abort asserted in WAIT of layer 3 together with eng_done → IDLE next cycle, no done, no further eng_start; a new start restarts at layer 0.
- start pulsed while busy, and spurious eng_done during ISSUE → ignored, sequence unchanged.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine silent on layer 2 → err=1 and done 16–17 cycles after that eng_start; err clears on next start.
- Async rst mid-layer 5 → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// Shared types and elaboration-time helpers for the decoder layer sequencer.
// Holds the FSM state type, the layer count and the function that builds
// each layer's configuration from the decoder channel counts and input size.
package decoder_seq_pkg;

  localparam int LAYER_N = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN,
    S_ERR
  } seq_state_t;

  // Channel and size fields are 8 bits wide. A count of 256 (4N at N=64)
  // wraps to 0, and the engine treats 0 as 256. Addresses are kept at 32
  // bits here, and each user slices them to its own address width.
  typedef struct packed {
    logic [7:0]  in_ch;
    logic [7:0]  out_ch;
    logic [7:0]  h;
    logic [7:0]  w;
    logic [31:0] wbase;
    logic [31:0] bbase;
    logic        ps_en;
    logic        relu_in;
    logic        res_add;
    logic [1:0]  ctx_sel;
  } layer_cfg_t;

  function automatic logic [31:0] layer_in_ch(input int k, input int n, input int m);
    case (k)
      0:       return 32'(m);
      1, 3, 6: return 32'(n);
      default: return 32'(2 * n);
    endcase
  endfunction

  function automatic logic [31:0] layer_out_ch(input int k, input int n);
    case (k)
      0, 1, 4: return 32'(4 * n);
      2, 5:    return 32'(n);
      3, 6:    return 32'(2 * n);
      default: return 32'd128;
    endcase
  endfunction

  // Each pixel-shuffle layer doubles the spatial size seen by the layers after it.
  function automatic logic [31:0] layer_scale(input int k);
    case (k)
      0:       return 32'd1;
      1:       return 32'd2;
      2, 3, 4: return 32'd4;
      default: return 32'd8;
    endcase
  endfunction

  function automatic layer_cfg_t layer_cfg(input int k, input int n, input int m,
                                           input int h, input int w);
    layer_cfg_t  cfg;
    logic [31:0] in_v;
    logic [31:0] out_v;
    logic [31:0] h_v;
    logic [31:0] w_v;
    logic [31:0] wsum;
    logic [31:0] bsum;
    wsum = 32'd0;
    bsum = 32'd0;
    for (int j = 0; j < k; j++) begin
      wsum = wsum + layer_out_ch(j, n) * layer_in_ch(j, n, m) * 32'd9;
      bsum = bsum + layer_out_ch(j, n);
    end
    in_v        = layer_in_ch(k, n, m);
    out_v       = layer_out_ch(k, n);
    h_v         = 32'(h) * layer_scale(k);
    w_v         = 32'(w) * layer_scale(k);
    cfg.in_ch   = in_v[7:0];
    cfg.out_ch  = out_v[7:0];
    cfg.h       = h_v[7:0];
    cfg.w       = w_v[7:0];
    cfg.wbase   = wsum;
    cfg.bbase   = bsum;
    cfg.ps_en   = (k == 0) || (k == 1) || (k == 4) || (k == 7);
    cfg.relu_in = (k == 2) || (k == 3) || (k == 5) || (k == 6);
    cfg.res_add = (k == 3) || (k == 6);
    cfg.ctx_sel = (k == 2) ? 2'd1 : ((k == 5) ? 2'd2 : 2'd0);
    return cfg;
  endfunction

endpackage

// File: rtl/decoder_layer_rom.sv
// Combinational layer_idx -> layer configuration lookup. The table is
// built once at elaboration from the decoder parameters, so the hardware
// is an 8-entry constant mux.
module decoder_layer_rom
  import decoder_seq_pkg::*;
#(
  parameter int CHANNEL_N = 64,
  parameter int CHANNEL_M = 96,
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 4,
  parameter int ADDR_W    = 24
) (
  input  logic [2:0]        layer_idx,
  output logic [7:0]        in_ch,
  output logic [7:0]        out_ch,
  output logic [7:0]        h,
  output logic [7:0]        w,
  output logic [ADDR_W-1:0] wbase,
  output logic [ADDR_W-1:0] bbase,
  output logic              ps_en,
  output logic              relu_in,
  output logic              res_add,
  output logic [1:0]        ctx_sel
);

  logic [7:0]        in_tab   [LAYER_N];
  logic [7:0]        out_tab  [LAYER_N];
  logic [7:0]        h_tab    [LAYER_N];
  logic [7:0]        w_tab    [LAYER_N];
  logic [ADDR_W-1:0] wb_tab   [LAYER_N];
  logic [ADDR_W-1:0] bb_tab   [LAYER_N];
  logic              ps_tab   [LAYER_N];
  logic              relu_tab [LAYER_N];
  logic              res_tab  [LAYER_N];
  logic [1:0]        ctx_tab  [LAYER_N];

  for (genvar k = 0; k < LAYER_N; k++) begin : g_layer
    localparam layer_cfg_t C = layer_cfg(k, CHANNEL_N, CHANNEL_M, HEIGHT, WIDTH);
    assign in_tab[k]   = C.in_ch;
    assign out_tab[k]  = C.out_ch;
    assign h_tab[k]    = C.h;
    assign w_tab[k]    = C.w;
    assign wb_tab[k]   = C.wbase[ADDR_W-1:0];
    assign bb_tab[k]   = C.bbase[ADDR_W-1:0];
    assign ps_tab[k]   = C.ps_en;
    assign relu_tab[k] = C.relu_in;
    assign res_tab[k]  = C.res_add;
    assign ctx_tab[k]  = C.ctx_sel;
  end

  // Select the entry for the requested layer.
  always_comb begin
    in_ch   = in_tab[layer_idx];
    out_ch  = out_tab[layer_idx];
    h       = h_tab[layer_idx];
    w       = w_tab[layer_idx];
    wbase   = wb_tab[layer_idx];
    bbase   = bb_tab[layer_idx];
    ps_en   = ps_tab[layer_idx];
    relu_in = relu_tab[layer_idx];
    res_add = res_tab[layer_idx];
    ctx_sel = ctx_tab[layer_idx];
  end

endmodule

// File: rtl/decoder_layer_sequencer.sv
// Runs the decoder's eight conv layers on one shared conv engine with a
// start/done handshake per layer, and presents a stable per-layer config.
// Optional feature: define SEQ_TIMEOUT_EN to add an engine watchdog that
// ends the pass with a sticky err flag. Without it, WAIT is unbounded.
module decoder_layer_sequencer
  import decoder_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CHANNEL_N      = 64,
  parameter int CHANNEL_M      = 96,
  parameter int HEIGHT         = 4,
  parameter int WIDTH          = 4,
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              eng_start,
  input  logic              eng_done,
  output logic [2:0]        layer_idx,
  output logic [7:0]        cfg_in_ch,
  output logic [7:0]        cfg_out_ch,
  output logic [7:0]        cfg_h,
  output logic [7:0]        cfg_w,
  output logic [ADDR_W-1:0] cfg_wbase,
  output logic [ADDR_W-1:0] cfg_bbase,
  output logic              cfg_ps_en,
  output logic              cfg_relu_in,
  output logic              cfg_res_add,
  output logic [1:0]        cfg_ctx_sel,
  output logic [31:0]       cycle_cnt
);

  seq_state_t        state_q, state_d;
  logic [2:0]        layer_d;
  logic              load_layer;
  logic              clr_pass;
  logic [7:0]        rom_in_ch, rom_out_ch, rom_h, rom_w;
  logic [ADDR_W-1:0] rom_wbase, rom_bbase;
  logic              rom_ps_en, rom_relu_in, rom_res_add;
  logic [1:0]        rom_ctx_sel;

  // The ROM is indexed by the next layer so the registered config changes
  // on the same edge as layer_idx and stays aligned with it.
  decoder_layer_rom #(
    .CHANNEL_N (CHANNEL_N),
    .CHANNEL_M (CHANNEL_M),
    .HEIGHT    (HEIGHT),
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_rom (
    .layer_idx (layer_d),
    .in_ch     (rom_in_ch),
    .out_ch    (rom_out_ch),
    .h         (rom_h),
    .w         (rom_w),
    .wbase     (rom_wbase),
    .bbase     (rom_bbase),
    .ps_en     (rom_ps_en),
    .relu_in   (rom_relu_in),
    .res_add   (rom_res_add),
    .ctx_sel   (rom_ctx_sel)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;

  // Counts cycles spent in WAIT. The count is cleared whenever the FSM is
  // outside WAIT, so every layer starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state_q != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state_q == S_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Sticky error flag: set when the FSM enters ERR, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err <= 1'b0;
    else if (clr_pass)          err <= 1'b0;
    else if (state_d == S_ERR)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs. Abort overrides everything,
  // including a same-cycle eng_done.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_idx;
    load_layer = 1'b0;
    clr_pass   = 1'b0;
    eng_start  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          layer_d    = 3'd0;
          load_layer = 1'b1;
          clr_pass   = 1'b1;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) state_d = S_NEXT;
`ifdef SEQ_TIMEOUT_EN
        else if (timeout) state_d = S_ERR;
`endif
      end
      S_NEXT: begin
        if (layer_idx == 3'(LAYER_N - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d    = S_ISSUE;
          layer_d    = layer_idx + 3'd1;
          load_layer = 1'b1;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      layer_d    = layer_idx;
      load_layer = 1'b0;
      eng_start  = 1'b0;
      done       = 1'b0;
    end
  end

  // Layer index and its registered configuration. Both load together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_idx   <= 3'd0;
      cfg_in_ch   <= '0;
      cfg_out_ch  <= '0;
      cfg_h       <= '0;
      cfg_w       <= '0;
      cfg_wbase   <= '0;
      cfg_bbase   <= '0;
      cfg_ps_en   <= 1'b0;
      cfg_relu_in <= 1'b0;
      cfg_res_add <= 1'b0;
      cfg_ctx_sel <= '0;
    end else if (load_layer) begin
      layer_idx   <= layer_d;
      cfg_in_ch   <= rom_in_ch;
      cfg_out_ch  <= rom_out_ch;
      cfg_h       <= rom_h;
      cfg_w       <= rom_w;
      cfg_wbase   <= rom_wbase;
      cfg_bbase   <= rom_bbase;
      cfg_ps_en   <= rom_ps_en;
      cfg_relu_in <= rom_relu_in;
      cfg_res_add <= rom_res_add;
      cfg_ctx_sel <= rom_ctx_sel;
    end
  end

  // Pass cycle counter: zeroed on an accepted start, saturates, and holds in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cycle_cnt <= 32'd0;
    else if (clr_pass)                     cycle_cnt <= 32'd0;
    else if (busy && (cycle_cnt != '1))    cycle_cnt <= cycle_cnt + 32'd1;
  end

endmodule

// File: tb/tb_decoder_layer_sequencer.sv
// Testbench for decoder_layer_sequencer: randomized engine latencies and
// handshake noise are checked against an event-time model of the pass.
module tb_decoder_layer_sequencer;

  localparam int N  = 64;
  localparam int M  = 96;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int AW = 24;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, eng_done;
  logic          busy, done, err, eng_start;
  logic [2:0]    layer_idx;
  logic [7:0]    cfg_in_ch, cfg_out_ch, cfg_h, cfg_w;
  logic [AW-1:0] cfg_wbase, cfg_bbase;
  logic          cfg_ps_en, cfg_relu_in, cfg_res_add;
  logic [1:0]    cfg_ctx_sel;
  logic [31:0]   cycle_cnt;

  decoder_layer_sequencer #(
    .DATA_WIDTH(32), .CHANNEL_N(N), .CHANNEL_M(M), .HEIGHT(H), .WIDTH(W),
    .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .eng_start(eng_start), .eng_done(eng_done), .layer_idx(layer_idx),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_h(cfg_h), .cfg_w(cfg_w),
    .cfg_wbase(cfg_wbase), .cfg_bbase(cfg_bbase), .cfg_ps_en(cfg_ps_en),
    .cfg_relu_in(cfg_relu_in), .cfg_res_add(cfg_res_add), .cfg_ctx_sel(cfg_ctx_sel),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;
  int exp_in[8], exp_out[8], exp_h[8], exp_w[8], exp_wb[8], exp_bb[8];
  int exp_ps[8], exp_relu[8], exp_res[8], exp_ctx[8];
  int lat[8];
  bit err_model = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_count++;
    if (obs !== expv) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit a, input bit d);
    @(negedge clk);
    start = s; abort = a; eng_done = d;
    #1;
  endtask

  // Layer table written out from the decoder's layer list.
  function automatic void build_model();
    int in_t[8]  = '{M, N, 2*N, N, 2*N, 2*N, N, 2*N};
    int out_t[8] = '{4*N, 4*N, N, 2*N, 4*N, N, 2*N, 128};
    int sz_t[8]  = '{1, 2, 4, 4, 4, 8, 8, 8};
    int wsum = 0;
    int bsum = 0;
    for (int k = 0; k < 8; k++) begin
      exp_in[k]   = in_t[k] % 256;
      exp_out[k]  = out_t[k] % 256;
      exp_h[k]    = (H * sz_t[k]) % 256;
      exp_w[k]    = (W * sz_t[k]) % 256;
      exp_wb[k]   = wsum % (1 << AW);
      exp_bb[k]   = bsum % (1 << AW);
      exp_ps[k]   = (k == 0 || k == 1 || k == 4 || k == 7) ? 1 : 0;
      exp_relu[k] = (k == 2 || k == 3 || k == 5 || k == 6) ? 1 : 0;
      exp_res[k]  = (k == 3 || k == 6) ? 1 : 0;
      exp_ctx[k]  = (k == 2) ? 1 : ((k == 5) ? 2 : 0);
      wsum += out_t[k] * in_t[k] * 9;
      bsum += out_t[k];
    end
  endfunction

  task automatic check_zero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_eng_start"}, 32'(eng_start), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_layer_idx"}, 32'(layer_idx), 0);
    checkOutput({tag, "_cfg_ch"}, {16'd0, cfg_in_ch, cfg_out_ch}, 0);
    checkOutput({tag, "_cfg_hw"}, {16'd0, cfg_h, cfg_w}, 0);
    checkOutput({tag, "_cfg_wbase"}, 32'(cfg_wbase), 0);
    checkOutput({tag, "_cfg_bbase"}, 32'(cfg_bbase), 0);
    checkOutput({tag, "_cfg_flags"}, {27'd0, cfg_ps_en, cfg_relu_in, cfg_res_add, cfg_ctx_sel}, 0);
    checkOutput({tag, "_cycle_cnt"}, cycle_cnt, 0);
  endtask

  // mode 0: full pass, 1: abort with eng_done in WAIT of layer 3,
  // 2: engine silent on layer 2 (watchdog), 3: async reset during layer 5.
  task automatic run_pass(input int mode, input int fixed_lat);
    int es[8];
    int ed[8];
    int done_t, end_t, n_issued;
    for (int k = 0; k < 8; k++) lat[k] = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
    if (mode == 2) lat[2] = 1000000;
    es[0] = 1;
    for (int k = 0; k < 8; k++) begin
      ed[k] = es[k] + lat[k];
      if (k < 7) es[k+1] = ed[k] + 2;
    end
    done_t = ed[7] + 2;
    n_issued = 8;
    if (mode == 1) begin
      end_t = ed[3]; n_issued = 4;
    end else if (mode == 2) begin
      done_t = es[2] + 17; end_t = done_t; n_issued = 3;
    end else if (mode == 3) begin
      end_t = es[5] + 1 + int'($urandom_range(0, lat[5] - 1)); n_issued = 6;
    end else begin
      end_t = done_t;
    end
    for (int c = 0; c <= end_t + 3; c++) begin
      bit s, a, d, exp_es, in_pass, exp_done;
      int exp_k;
      s = (c == 0) || (c >= 1 && c < end_t && $urandom_range(0, 4) == 0);
      a = (mode == 1 && c == end_t);
      d = 1'b0; exp_es = 1'b0; exp_k = 0;
      for (int k = 0; k < n_issued; k++) begin
        if (c == es[k]) begin
          exp_es = 1'b1; exp_k = k;
          if ($urandom_range(0, 1) == 1) d = 1'b1;
        end
        if (c == ed[k]) d = 1'b1;
        if (c == ed[k] + 1 && $urandom_range(0, 2) == 0) d = 1'b1;
      end
      if (c > end_t) begin
        d = 1'b0; exp_es = 1'b0;
      end
      applyStimulus(s, a, d);
      if (c == 1) err_model = 1'b0;
      if (mode == 2 && c == done_t) err_model = 1'b1;
      in_pass  = (c >= 1 && c <= end_t);
      exp_done = (mode == 0 || mode == 2) && (c == done_t);
      checkOutput("busy", 32'(busy), 32'(in_pass));
      checkOutput("eng_start", 32'(eng_start), 32'(exp_es));
      checkOutput("done", 32'(done), 32'(exp_done));
      checkOutput("err", 32'(err), 32'(err_model));
      if (exp_es) begin
        checkOutput("layer_idx", 32'(layer_idx), exp_k);
        checkOutput("cfg_in_ch", 32'(cfg_in_ch), exp_in[exp_k]);
        checkOutput("cfg_out_ch", 32'(cfg_out_ch), exp_out[exp_k]);
        checkOutput("cfg_h", 32'(cfg_h), exp_h[exp_k]);
        checkOutput("cfg_w", 32'(cfg_w), exp_w[exp_k]);
        checkOutput("cfg_wbase", 32'(cfg_wbase), exp_wb[exp_k]);
        checkOutput("cfg_bbase", 32'(cfg_bbase), exp_bb[exp_k]);
        checkOutput("cfg_ps_en", 32'(cfg_ps_en), exp_ps[exp_k]);
        checkOutput("cfg_relu_in", 32'(cfg_relu_in), exp_relu[exp_k]);
        checkOutput("cfg_res_add", 32'(cfg_res_add), exp_res[exp_k]);
        checkOutput("cfg_ctx_sel", 32'(cfg_ctx_sel), exp_ctx[exp_k]);
      end
      if (exp_done) checkOutput("cycle_cnt_at_done", cycle_cnt, done_t - 1);
      if (mode == 3 && c == end_t) begin
        #1 rst = 1'b1;
        #1 check_zero("async_rst");
        err_model = 1'b0;
        #1 rst = 1'b0;
      end
      if (c == end_t + 2) checkOutput("cycle_cnt_after", cycle_cnt, (mode == 3) ? 0 : end_t);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    build_model();
    rst = 1'b1; start = 1'b0; abort = 1'b0; eng_done = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    run_pass(0, 5);
    for (int i = 0; i < 3; i++) run_pass(0, 0);
    run_pass(1, 0);
    run_pass(0, 0);
`ifdef SEQ_TIMEOUT_EN
    run_pass(2, 0);
    run_pass(0, 0);
`endif
    run_pass(3, 0);
    run_pass(0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
